// File: rtl/btb_assoc.sv
// 2-way set-associative branch target buffer with 2-bit direction counters, per-set LRU,
// an EX-stage update port and a post-reset invalidate sweep over the tag/data RAMs.
module btb_assoc #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 8,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] PC,
    output logic            hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] target_PC,
    output logic            hit_way,
    output logic            busy,
    input  logic            upd_vld,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_hit,
    input  logic            upd_way,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_tgt,
    output logic            inc_br_cnt,
    output logic            inc_hit_cnt,
    output logic            inc_mispr_cnt
);

    localparam int TAG_W = PC_W - IDX_W;
    localparam int SETS  = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [SETS-1:0]  lru_q, lru_d;

    logic            hit_q, hit_d;
    logic            pred_taken_q, pred_taken_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            hit_way_q, hit_way_d;

    // RAM arrays: no reset, the sweep clears the valid bits instead
    logic             valid_mem [2][SETS];
    logic [TAG_W-1:0] tag_mem   [2][SETS];
    logic [CNT_W-1:0] cnt_mem   [2][SETS];
    logic [PC_W-1:0]  tgt_mem   [2][SETS];

    logic [IDX_W-1:0] lk_idx, upd_idx, wr_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_m0, lk_m1;
    logic [CNT_W-1:0] cnt_rd, cnt_wdata;
    logic             victim, wr_way;
    logic [1:0]       vld_we;
    logic             vld_wdata, tag_we, cnt_we, tgt_we;
    logic             mispredict;

    assign lk_idx  = PC[IDX_W-1:0];
    assign lk_tag  = PC[PC_W-1:IDX_W];
    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[PC_W-1:IDX_W];

    assign lk_m0  = valid_mem[0][lk_idx] && (tag_mem[0][lk_idx] == lk_tag);
    assign lk_m1  = valid_mem[1][lk_idx] && (tag_mem[1][lk_idx] == lk_tag);
    assign cnt_rd = cnt_mem[upd_way][upd_idx];

    // Allocation prefers an empty way (way 0 first) before evicting the LRU way
    assign victim = !valid_mem[0][upd_idx] ? 1'b0 :
                    !valid_mem[1][upd_idx] ? 1'b1 : lru_q[upd_idx];

    assign mispredict = (upd_pred_taken != upd_taken) ||
                        (upd_taken && upd_pred_taken && (upd_pred_tgt != upd_target));

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lru_d        = lru_q;
        hit_d        = 1'b0;
        pred_taken_d = 1'b0;
        target_d     = '0;
        hit_way_d    = 1'b0;
        vld_we       = 2'b00;
        vld_wdata    = 1'b0;
        tag_we       = 1'b0;
        cnt_we       = 1'b0;
        tgt_we       = 1'b0;
        cnt_wdata    = cnt_rd;
        wr_way       = upd_way;
        wr_idx       = upd_idx;
        case (state_q)
            S_INIT: begin
                vld_we = 2'b11;
                wr_idx = ptr_q;
                ptr_d  = ptr_q + 1'b1;
                if (&ptr_q) state_d = S_RUN;
            end
            default: begin
                // Way 0 wins if both ways match; that case is flagged by the assertion below
                if (lk_m0) begin
                    hit_d        = 1'b1;
                    pred_taken_d = cnt_mem[0][lk_idx][CNT_W-1];
                    target_d     = tgt_mem[0][lk_idx];
                end else if (lk_m1) begin
                    hit_d        = 1'b1;
                    hit_way_d    = 1'b1;
                    pred_taken_d = cnt_mem[1][lk_idx][CNT_W-1];
                    target_d     = tgt_mem[1][lk_idx];
                end
                if (upd_vld && upd_hit) begin
                    cnt_we = 1'b1;
                    tgt_we = upd_taken;
                    if (upd_taken)
                        cnt_wdata = (cnt_rd == CNT_MAX) ? cnt_rd : cnt_rd + CNT_W'(1);
                    else
                        cnt_wdata = (cnt_rd == '0) ? cnt_rd : cnt_rd - CNT_W'(1);
                    lru_d[upd_idx] = ~upd_way;
                end else if (upd_vld && upd_taken) begin
                    wr_way         = victim;
                    vld_we[victim] = 1'b1;
                    vld_wdata      = 1'b1;
                    tag_we         = 1'b1;
                    cnt_we         = 1'b1;
                    tgt_we         = 1'b1;
                    cnt_wdata      = CNT_WEAK;
                    lru_d[upd_idx] = ~victim;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            ptr_q        <= '0;
            lru_q        <= '0;
            hit_q        <= 1'b0;
            pred_taken_q <= 1'b0;
            target_q     <= '0;
            hit_way_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lru_q        <= lru_d;
            hit_q        <= hit_d;
            pred_taken_q <= pred_taken_d;
            target_q     <= target_d;
            hit_way_q    <= hit_way_d;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_we[0]) valid_mem[0][wr_idx] <= vld_wdata;
        if (vld_we[1]) valid_mem[1][wr_idx] <= vld_wdata;
        if (tag_we)    tag_mem[wr_way][wr_idx] <= upd_tag;
        if (cnt_we)    cnt_mem[wr_way][wr_idx] <= cnt_wdata;
        if (tgt_we)    tgt_mem[wr_way][wr_idx] <= upd_target;
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == S_RUN) && lk_m0 && lk_m1));

    assign busy          = (state_q == S_INIT);
    assign hit           = hit_q;
    assign pred_taken    = pred_taken_q;
    assign target_PC     = target_q;
    assign hit_way       = hit_way_q;
    assign inc_hit_cnt   = hit_q;
    assign inc_br_cnt    = upd_vld && !busy;
    assign inc_mispr_cnt = upd_vld && !busy && mispredict;

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: a set/way reference model predicts every lookup and
// stat pulse; two monitor processes pop the expectations and compare against the DUT.
module tb_btb_assoc;

    localparam int PC_W  = 16;
    localparam int IDX_W = 8;
    localparam int CNT_W = 2;
    localparam int SETS  = 256;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PC_W-1:0] PC = '0;
    logic            hit, pred_taken, hit_way, busy;
    logic [PC_W-1:0] target_PC;
    logic            upd_vld = 1'b0, upd_taken = 1'b0, upd_hit = 1'b0, upd_way = 1'b0;
    logic            upd_pred_taken = 1'b0;
    logic [PC_W-1:0] upd_pc = '0, upd_target = '0, upd_pred_tgt = '0;
    logic            inc_br_cnt, inc_hit_cnt, inc_mispr_cnt;

    always #5 clk = ~clk;

    btb_assoc #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .PC(PC),
        .hit(hit), .pred_taken(pred_taken), .target_PC(target_PC), .hit_way(hit_way),
        .busy(busy),
        .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_hit(upd_hit), .upd_way(upd_way), .upd_pred_taken(upd_pred_taken),
        .upd_pred_tgt(upd_pred_tgt),
        .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt), .inc_mispr_cnt(inc_mispr_cnt)
    );

    typedef struct packed {
        logic        hit;
        logic        way;
        logic        pt;
        logic [15:0] tgt;
    } look_t;

    typedef struct packed {
        logic br;
        logic mispr;
    } stat_t;

    look_t lookQ[$];
    stat_t statQ[$];
    int compared = 0;
    int mismatched = 0;

    // Reference model: what each set holds, and which way gets replaced next
    bit          mV   [2][SETS];
    logic [7:0]  mTag [2][SETS];
    int          mCnt [2][SETS];
    logic [15:0] mTgt [2][SETS];
    bit          mNextVictim [SETS];
    logic [7:0]  tagPool [4] = '{8'h00, 8'h12, 8'h22, 8'h55};

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        for (int s = 0; s < SETS; s++) begin
            mV[0][s] = 0;
            mV[1][s] = 0;
            mNextVictim[s] = 0;
        end
    endfunction

    function automatic look_t modelLookup(logic [15:0] pc);
        look_t r = '0;
        int s = int'(pc[7:0]);
        for (int w = 1; w >= 0; w--) begin
            if (mV[w][s] && mTag[w][s] == pc[15:8]) begin
                r.hit = 1'b1;
                r.way = (w == 1);
                r.pt  = (mCnt[w][s] >= 2);
                r.tgt = mTgt[w][s];
            end
        end
        return r;
    endfunction

    function automatic void modelUpdate(logic [15:0] pc, bit taken, logic [15:0] tgt,
                                        bit uHit, bit uWay);
        int s = int'(pc[7:0]);
        int w;
        if (uHit) begin
            w = uWay ? 1 : 0;
            if (taken) begin
                mCnt[w][s] = (mCnt[w][s] == 3) ? 3 : mCnt[w][s] + 1;
                mTgt[w][s] = tgt;
            end else begin
                mCnt[w][s] = (mCnt[w][s] == 0) ? 0 : mCnt[w][s] - 1;
            end
            mNextVictim[s] = !uWay;
        end else if (taken) begin
            if (!mV[0][s])      w = 0;
            else if (!mV[1][s]) w = 1;
            else                w = mNextVictim[s] ? 1 : 0;
            mV[w][s]   = 1;
            mTag[w][s] = pc[15:8];
            mCnt[w][s] = 2;
            mTgt[w][s] = tgt;
            mNextVictim[s] = (w == 0);
        end
    endfunction

    function automatic logic [15:0] randPc();
        logic [7:0] idx;
        case ($urandom_range(0, 3))
            0:       idx = 8'h34;
            1:       idx = 8'h35;
            2:       idx = 8'h36;
            default: idx = 8'($urandom);
        endcase
        return {tagPool[$urandom_range(0, 3)], idx};
    endfunction

    // One RUN-mode cycle: drive at negedge, queue expectations, then advance the model
    task automatic applyStimulus(logic [15:0] pc, bit doUpd, logic [15:0] uPc, bit taken,
                                 logic [15:0] uTgt, int staleWay);
        look_t cur, info;
        stat_t st;
        bit    mis;
        @(negedge clk);
        cur  = modelLookup(pc);
        info = modelLookup(uPc);
        if (staleWay >= 0) begin
            info.hit = 1'b1;
            info.way = (staleWay == 1);
            info.pt  = 1'b0;
            info.tgt = '0;
        end
        PC             = pc;
        upd_vld        = doUpd;
        upd_pc         = uPc;
        upd_taken      = taken;
        upd_target     = uTgt;
        upd_hit        = info.hit;
        upd_way        = info.way;
        upd_pred_taken = info.pt;
        upd_pred_tgt   = (info.hit && info.pt) ? info.tgt : 16'h0;
        mis = (info.pt != taken) || (taken && info.pt && upd_pred_tgt != uTgt);
        st.br    = doUpd;
        st.mispr = doUpd && mis;
        lookQ.push_back(cur);
        statQ.push_back(st);
        if (doUpd) modelUpdate(uPc, taken, uTgt, info.hit, info.way);
    endtask

    task automatic expectLookup(string name, bit h, bit pt, logic [15:0] tgt, bit way);
        @(posedge clk);
        #2;
        checkOutput({name, " hit"}, hit, h);
        checkOutput({name, " pred_taken"}, pred_taken, pt);
        checkOutput({name, " target_PC"}, target_PC, tgt);
        checkOutput({name, " hit_way"}, hit_way, way);
    endtask

    task automatic checkResetOutputs(string name);
        checkOutput({name, " busy"}, busy, 1);
        checkOutput({name, " hit"}, hit, 0);
        checkOutput({name, " pred_taken"}, pred_taken, 0);
        checkOutput({name, " target_PC"}, target_PC, 0);
        checkOutput({name, " hit_way"}, hit_way, 0);
        checkOutput({name, " inc_hit_cnt"}, inc_hit_cnt, 0);
        checkOutput({name, " inc_br_cnt"}, inc_br_cnt, 0);
        checkOutput({name, " inc_mispr_cnt"}, inc_mispr_cnt, 0);
    endtask

    // Release reset and count cycles until busy drops, hammering the ports meanwhile
    task automatic sweepCheck(string name);
        int edges = 0;
        bit sawLookup = 0, sawPulse = 0, done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        while (!done && edges < 1000) begin
            PC             = 16'($urandom);
            upd_vld        = 1'b1;
            upd_pc         = 16'($urandom);
            upd_taken      = 1'($urandom);
            upd_target     = 16'($urandom);
            upd_hit        = 1'($urandom);
            upd_way        = 1'($urandom);
            upd_pred_taken = 1'($urandom);
            upd_pred_tgt   = 16'($urandom);
            #1;
            if (inc_br_cnt || inc_mispr_cnt) sawPulse = 1;
            @(posedge clk);
            #1;
            edges++;
            if (hit || pred_taken || target_PC != 0 || hit_way || inc_hit_cnt) sawLookup = 1;
            if (!busy) done = 1;
            else @(negedge clk);
        end
        upd_vld = 1'b0;
        checkOutput({name, " sweep cycles"}, edges, 256);
        checkOutput({name, " lookup during sweep"}, 32'(sawLookup), 0);
        checkOutput({name, " stat pulse during sweep"}, 32'(sawPulse), 0);
    endtask

    // Lookup monitor: one expectation per registered lookup result
    initial begin
        look_t e;
        forever begin
            @(posedge clk);
            #1;
            if (lookQ.size() > 0) begin
                e = lookQ.pop_front();
                checkOutput("sb hit", hit, e.hit);
                checkOutput("sb pred_taken", pred_taken, e.pt);
                checkOutput("sb target_PC", target_PC, e.hit ? e.tgt : 16'h0);
                checkOutput("sb hit_way", hit_way, e.hit ? e.way : 1'b0);
                checkOutput("sb inc_hit_cnt", inc_hit_cnt, e.hit);
                checkOutput("sb busy", busy, 0);
            end
        end
    end

    // Stat monitor: combinational pulses checked shortly after each drive
    initial begin
        stat_t s;
        forever begin
            @(negedge clk);
            #2;
            if (statQ.size() > 0) begin
                s = statQ.pop_front();
                checkOutput("sb inc_br_cnt", inc_br_cnt, s.br);
                checkOutput("sb inc_mispr_cnt", inc_mispr_cnt, s.mispr);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int stale;
        logic [15:0] pc, up;

        upd_vld = 1'b1;
        #12;
        checkResetOutputs("reset");

        // Interrupt the first sweep at ptr=100; the next sweep must start over at set 0
        @(negedge clk);
        rst_n = 1'b1;
        upd_vld = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("busy before mid-sweep reset", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        upd_vld = 1'b1;
        #1;
        checkResetOutputs("mid-sweep reset");
        sweepCheck("first");

        // Directed sequence on set 0x34
        applyStimulus(16'h0000, 1, 16'h1234, 1, 16'h2000, -1);
        applyStimulus(16'h1234, 0, 16'h0000, 0, 16'h0000, -1);
        expectLookup("alloc 0x1234", 1, 1, 16'h2000, 0);
        applyStimulus(16'h1234, 1, 16'h1234, 0, 16'h0000, -1);
        #1 checkOutput("mispredict first dec", inc_mispr_cnt, 1);
        applyStimulus(16'h1234, 1, 16'h1234, 0, 16'h0000, -1);
        #1 checkOutput("mispredict second dec", inc_mispr_cnt, 0);
        applyStimulus(16'h1234, 0, 16'h0000, 0, 16'h0000, -1);
        expectLookup("cnt 0", 1, 0, 16'h2000, 0);
        applyStimulus(16'h1234, 1, 16'h1234, 0, 16'h0000, -1);
        applyStimulus(16'h1234, 1, 16'h1234, 1, 16'h2000, -1);
        applyStimulus(16'h1234, 0, 16'h0000, 0, 16'h0000, -1);
        expectLookup("cnt no wrap", 1, 0, 16'h2000, 0);
        applyStimulus(16'h0000, 1, 16'h0034, 1, 16'h4000, -1);
        applyStimulus(16'h0000, 1, 16'h1234, 1, 16'h2000, -1);
        applyStimulus(16'h0000, 1, 16'h2234, 1, 16'h5000, -1);
        applyStimulus(16'h0034, 0, 16'h0000, 0, 16'h0000, -1);
        expectLookup("evicted 0x0034", 0, 0, 16'h0000, 0);
        applyStimulus(16'h1234, 0, 16'h0000, 0, 16'h0000, -1);
        expectLookup("kept 0x1234", 1, 1, 16'h2000, 0);
        applyStimulus(16'h2234, 0, 16'h0000, 0, 16'h0000, -1);
        expectLookup("new 0x2234", 1, 1, 16'h5000, 1);
        applyStimulus(16'h1234, 1, 16'h1234, 1, 16'h3000, -1);
        expectLookup("read before write", 1, 1, 16'h2000, 0);
        applyStimulus(16'h1234, 0, 16'h0000, 0, 16'h0000, -1);
        expectLookup("after write", 1, 1, 16'h3000, 0);
        applyStimulus(16'h0000, 1, 16'h5534, 0, 16'h0000, 1);
        applyStimulus(16'h2234, 0, 16'h0000, 0, 16'h0000, -1);
        expectLookup("stale way update", 1, 0, 16'h5000, 1);

        // Randomised traffic over a few crowded sets
        for (int i = 0; i < 3000; i++) begin
            pc = randPc();
            up = randPc();
            stale = -1;
            if ($urandom_range(0, 19) == 0) begin
                stale = int'($urandom_range(0, 1));
                if (!mV[stale][int'(up[7:0])]) stale = -1;
            end
            applyStimulus(pc, $urandom_range(0, 9) < 7, up, $urandom_range(0, 9) < 6,
                          16'($urandom), stale);
        end
        @(negedge clk);
        upd_vld = 1'b0;
        repeat (3) @(posedge clk);
        checkOutput("scoreboard drained", lookQ.size(), 0);

        // Reset mid-run: the sweep must invalidate everything learned so far
        @(negedge clk);
        rst_n = 1'b0;
        upd_vld = 1'b1;
        #1;
        checkResetOutputs("run reset");
        sweepCheck("second");
        applyStimulus(16'h1234, 0, 16'h0000, 0, 16'h0000, -1);
        expectLookup("cleared 0x1234", 0, 0, 16'h0000, 0);
        applyStimulus(16'h0000, 1, 16'h1234, 1, 16'h6000, -1);
        applyStimulus(16'h1234, 0, 16'h0000, 0, 16'h0000, -1);
        expectLookup("realloc 0x1234", 1, 1, 16'h6000, 0);
        @(negedge clk);
        upd_vld = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
